layer_argmax: RTL

LAYER_ARGMAX -- requirements
Module: layer_argmax

---
 rtl/layer_argmax_pkg.sv | 20 ++
 rtl/layer_argmax.sv | 108 ++++++++++
 2 files changed

// File: rtl/layer_argmax_pkg.sv
// Shared NN package: Q4.4 activation format and the argmax FSM encoding.
// The layer stages import the same constants so every stage agrees on the
// activation format.
package layer_argmax_pkg;

  // Q4.4 signed activations: 8 bits total, 4 fractional bits.
  localparam int Q_W    = 8;
  localparam int Q_FRAC = 4;

  // Argmax controller states (plain constants so legacy stages can reuse them).
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Index width for n entries: ceil(log2(n)), but never less than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/layer_argmax.sv
// Sequential argmax over one frame of N signed Q4.4 activations.
// The stage captures a whole frame on req, then compares one element per
// cycle. Ties keep the lower index. The result is held until downstream
// takes it, and a saturating counter records completed frames.
module layer_argmax
  import layer_argmax_pkg::*;
#(
  parameter  int N  = 2,
  parameter  int W  = Q_W,
  localparam int IW = idx_width(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req,
  input  logic [N*W-1:0] vals,
  output logic           ack,
  output logic           out_valid,
  output logic [IW-1:0]  out_idx,
  output logic [W-1:0]   out_val,
  input  logic           out_ready,
  output logic [15:0]    frames
);

  logic [1:0]          state_q;
  logic [N*W-1:0]      buf_q;
  logic [IW-1:0]       scan_i;
  logic [IW-1:0]       best_idx;
  logic signed [W-1:0] best_val;

  // Element under comparison this cycle, and the running winner after it.
  logic signed [W-1:0] cand;
  logic                cand_wins;
  logic                last_elem;

  assign cand      = buf_q[int'(scan_i)*W +: W];
  // Strict greater-than, so an equal value never displaces a lower index.
  assign cand_wins = cand > best_val;
  assign last_elem = (int'(scan_i) == N - 1);

  // Frame capture, element-by-element scan, and the result handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      // NOTE: the frame buffer is reset too, so a frame aborted by reset
      // leaves no stale activations behind for the next capture.
      buf_q     <= '0;
      scan_i    <= '0;
      best_idx  <= '0;
      best_val  <= '0;
      ack       <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_val   <= '0;
      frames    <= '0;
    end else begin
      // NOTE: all state here uses non-blocking assignments. Every branch
      // then reads pre-edge values, whatever order the statements are in.
      ack <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            buf_q    <= vals;
            ack      <= 1'b1;
            best_val <= vals[W-1:0];
            best_idx <= '0;
            scan_i   <= IW'(1);
            if (N == 1) begin
              // A single element is its own maximum, so the scan is skipped.
              state_q   <= ST_DONE;
              out_valid <= 1'b1;
              out_idx   <= '0;
              out_val   <= vals[W-1:0];
            end else begin
              state_q <= ST_SCAN;
            end
          end
        end

        ST_SCAN: begin
          if (cand_wins) begin
            best_val <= cand;
            best_idx <= scan_i;
          end
          scan_i <= scan_i + 1'b1;
          if (last_elem) begin
            state_q   <= ST_DONE;
            out_valid <= 1'b1;
            out_idx   <= cand_wins ? scan_i : best_idx;
            out_val   <= cand_wins ? cand : best_val;
          end
        end

        ST_DONE: begin
          if (out_ready) begin
            state_q   <= ST_IDLE;
            out_valid <= 1'b0;
            if (frames != 16'hFFFF) begin
              frames <= frames + 16'd1;
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
